instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage directly downstream of program_counter: latches the current PC, issues a single-word
//  instruction read to memory, holds the returned instruction until the decode stage accepts it,
//  then pulses o_load_PC so program_counter advances by 4 or takes the pending jump.
//  One outstanding memory read at most. Flush and timeout handling included.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles waiting for i_mem_DV before fault; 0 disables the timeout
//  TO_WIDTH        9    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  i_clk           in   1   clock, all logic on posedge
//  i_reset         in   1   synchronous, active-high reset
//  i_enable        in   1   fetch permitted; sampled in S_IDLE only
//  i_PC            in   32  current PC from program_counter (o_PC)
//  o_load_PC       out  1   one-cycle pulse to program_counter i_load_PC
//  o_mem_addr      out  32  instruction address, word-aligned
//  o_mem_read      out  1   read request; held high for the whole S_FETCH state
//  i_mem_DV        in   1   memory data valid; one-cycle pulse
//  i_mem_data      in   32  instruction word, valid with i_mem_DV
//  o_instr         out  32  captured instruction
//  o_instr_PC      out  32  address o_instr was fetched from
//  o_instr_DV      out  1   o_instr valid; held until accepted
//  i_instr_ack     in   1   decode accepts o_instr; only meaningful while o_instr_DV=1
//  i_flush         in   1   discard current instruction or fetch; redirect pending
//  o_fetch_fault   out  1   sticky fault flag; cleared only by reset
// BEHAVIOUR
//  Reset: state S_IDLE; all outputs 0; drop flag 0; timeout counter 0.
//  S_IDLE: if i_enable, latch i_PC into o_mem_addr and o_instr_PC, then go to S_FETCH (1 cycle).
//  S_FETCH: o_mem_read=1. On i_mem_DV: capture i_mem_data into o_instr, go to S_VALID.
//    On i_mem_DV with the drop flag set: discard the data, clear drop, go to S_STEP.
//  S_VALID: o_instr_DV=1.
//    i_instr_ack: go to S_STEP.
//    i_flush: go to S_STEP with no ack; o_instr_DV drops the next cycle.
//  S_STEP: o_load_PC=1 for exactly one cycle; program_counter updates on this edge. Go to S_IDLE.
//    The new PC is visible in S_IDLE, so instructions issue back to back every 4+ cycles.
//  Flush in S_FETCH: set the drop flag and stay in S_FETCH until i_mem_DV; the read is never abandoned.
//  Flush in S_IDLE/S_STEP: ignored. A redirect issued there is taken by the next o_load_PC.
//  Redirect contract: the jump source holds program_counter i_jump_DV/i_jump_address until it sees
//    o_load_PC=1. The fetch stage never generates addresses itself.
//  Simultaneous i_flush and i_instr_ack in S_VALID: flush wins; identical transition, instruction dropped.
//  Simultaneous i_flush and i_mem_DV in S_FETCH: data dropped, go to S_STEP.
//  Timeout: counter runs in S_FETCH and clears on leaving it. When count==TIMEOUT_CYCLES-1 with no
//    i_mem_DV, set o_fetch_fault and enter S_FAULT. S_FAULT: all strobes 0; exit only on i_reset.
//  Reset mid-fetch: return to S_IDLE immediately. A late i_mem_DV arriving in S_IDLE is ignored.
//  PC wrap 0xFFFFFFFC->0 is handled by program_counter; no special case here.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: in S_IDLE, if i_enable and i_PC[1:0]!=0, set o_fetch_fault, go to
//    S_FAULT, issue no read.
//  FETCH_ALIGN_CHECK_EN undefined: o_mem_addr = {i_PC[31:2],2'b00}; low bits silently ignored;
//    o_fetch_fault set by timeout only.
// TESTING
//  1) Reset, i_PC=0, memory replies 2 cycles after read with 0x00000013, ack at once -> o_instr=0x13,
//     o_instr_PC=0, one o_load_PC pulse; next o_mem_addr=0x4.
//  2) Hold i_instr_ack=0 for 10 cycles -> o_instr_DV and o_instr stay stable; o_load_PC stays 0.
//  3) Flush in S_FETCH, then i_mem_DV with 0xDEADBEEF -> o_instr_DV never rises; one o_load_PC;
//     program_counter jump to 0x100 taken; next read at 0x100.
//  4) TIMEOUT_CYCLES=8, no i_mem_DV -> o_fetch_fault=1 on cycle 8 of S_FETCH, o_mem_read=0;
//     stuck until i_reset.
//  5) Reset asserted mid S_FETCH, stray i_mem_DV one cycle later -> no capture; restart fetches i_PC.
//  6) With FETCH_ALIGN_CHECK_EN, i_PC=0x2 -> o_fetch_fault=1, o_mem_read never asserted;
//     without it, read issued at 0x0.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch stage between program_counter and decode
// Optional feature macro: FETCH_ALIGN_CHECK_EN (fault on a misaligned PC instead of masking the low bits)
module instruction_fetch #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_WIDTH       = 9
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_PC,
  output logic        o_load_PC,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_read,
  input  logic        i_mem_DV,
  input  logic [31:0] i_mem_data,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_PC,
  output logic        o_instr_DV,
  input  logic        i_instr_ack,
  input  logic        i_flush,
  output logic        o_fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_VALID = 3'd2,
    S_STEP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // A zero TIMEOUT_CYCLES disables the watchdog entirely; the counter then stays at zero.
  localparam bit                  TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TO_WIDTH-1:0] TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              next_state;
  logic                drop;
  logic [TO_WIDTH-1:0] to_count;
  logic [31:0]         pc_aligned;
  logic                misaligned;
  logic                timeout_hit;
  logic                start_fetch;
  logic                capture;

  assign pc_aligned = {i_PC[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (i_PC[1:0] != 2'b00);
`else
  // Low PC bits are simply masked off; keep them referenced so they are visibly intentional.
  logic unused_pc_low;
  assign misaligned    = 1'b0;
  assign unused_pc_low = ^i_PC[1:0];
`endif

  // Watchdog fires on the last permitted wait cycle unless data arrives in that same cycle.
  assign timeout_hit = TO_EN && (to_count == TO_LAST) && !i_mem_DV;

  // A read that was flushed (now or earlier) still completes, but its data is thrown away.
  assign capture     = (state == S_FETCH) && i_mem_DV && !drop && !i_flush;
  assign start_fetch = (state == S_IDLE) && i_enable && !misaligned;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the state-decoded strobes.
  always_comb begin
    next_state = state;
    o_mem_read = 1'b0;
    o_instr_DV = 1'b0;
    o_load_PC  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_enable) begin
          next_state = misaligned ? S_FAULT : S_FETCH;
        end
      end
      S_FETCH: begin
        o_mem_read = 1'b1;
        if (i_mem_DV) begin
          next_state = (drop || i_flush) ? S_STEP : S_VALID;
        end else if (timeout_hit) begin
          next_state = S_FAULT;
        end
      end
      S_VALID: begin
        o_instr_DV = 1'b1;
        // Flush and ack lead to the same place; a flush simply means decode never took it.
        if (i_flush || i_instr_ack) begin
          next_state = S_STEP;
        end
      end
      S_STEP: begin
        o_load_PC  = 1'b1;
        next_state = S_IDLE;
      end
      S_FAULT: begin
        next_state = S_FAULT;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Latch the fetch address once per instruction; it stays put until the next fetch starts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mem_addr <= 32'd0;
      o_instr_PC <= 32'd0;
    end else if (start_fetch) begin
      o_mem_addr <= pc_aligned;
      o_instr_PC <= pc_aligned;
    end
  end

  // Capture returned instruction data only for a read that has not been flushed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_instr <= 32'd0;
    end else if (capture) begin
      o_instr <= i_mem_data;
    end
  end

  // Drop flag remembers a flush seen while the read is still outstanding.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      drop <= 1'b0;
    end else if (state == S_FETCH) begin
      if (i_mem_DV) begin
        drop <= 1'b0;
      end else if (i_flush) begin
        drop <= 1'b1;
      end
    end else begin
      drop <= 1'b0;
    end
  end

  // Wait-cycle counter: runs only while a read is outstanding, cleared everywhere else.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      to_count <= '0;
    end else if (TO_EN && (state == S_FETCH)) begin
      to_count <= to_count + TO_ONE;
    end else begin
      to_count <= '0;
    end
  end

  // Sticky fault flag, set on any entry into S_FAULT and cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fetch_fault <= 1'b0;
    end else if ((next_state == S_FAULT) && (state != S_FAULT)) begin
      o_fetch_fault <= 1'b1;
    end
  end

endmodule
